// File: rtl/pwm_duty_capture_pkg.sv
// pwm_duty_capture_pkg
//   Shared constants for the three-channel PWM duty-cycle meter.
//   Status word layout : [8:0] active_count, [13:9] zero, [14] edge_seen, [15] valid
//   Control word layout: [0] enable, [1] clear_flags (level), [15:2] ignored
package pwm_duty_capture_pkg;

   localparam int STATUS_W   = 16;
   localparam int CONTROL_W  = 16;

   localparam int COUNT_LSB  = 0;
   localparam int COUNT_MSB  = 8;
   localparam int EDGE_BIT   = 14;
   localparam int VALID_BIT  = 15;

   localparam int ENABLE_BIT = 0;
   localparam int CLEAR_BIT  = 1;

   typedef struct packed {
      logic enable;
      logic clear;
   } ctrl_t;

   // Pull the two meaningful bits out of the control word; the rest is ignored.
   function automatic ctrl_t decode_control(input logic [CONTROL_W-1:0] word);
      ctrl_t c;
      c.enable = word[ENABLE_BIT];
      c.clear  = word[CLEAR_BIT];
      return c;
   endfunction

endpackage

// File: rtl/pwm_duty_capture_if.sv
// pwm_duty_capture_if
//   Bundles the PWM pins, the control word and the three status words.
//   master : the CPU / environment side (drives pins and control, reads status)
//   slave  : the meter (samples pins and control, drives status)
//   The status words are plain registers: a read simply samples the current
//   value, there is no request/acknowledge handshake on this bus.
interface pwm_duty_capture_if;
   import pwm_duty_capture_pkg::*;

   logic                  pwm_red;
   logic                  pwm_grn;
   logic                  pwm_blu;
   logic [CONTROL_W-1:0]  control;
   logic [STATUS_W-1:0]   status_red;
   logic [STATUS_W-1:0]   status_grn;
   logic [STATUS_W-1:0]   status_blu;

   modport master (
      output pwm_red, pwm_grn, pwm_blu, control,
      input  status_red, status_grn, status_blu
   );

   modport slave (
      input  pwm_red, pwm_grn, pwm_blu, control,
      output status_red, status_grn, status_blu
   );

endinterface

// File: rtl/pwm_duty_capture_channel_meter.sv
// pwm_channel_meter
//   One PWM channel: input synchroniser, falling-edge detect, active-cycle
//   accumulator and the published status register.
//   Ports:
//     clock, reset  - system clock, async active-high reset
//     pwm_n         - active-low PWM pin, asynchronous to clock
//     enable        - meter enabled (0 forces everything to zero)
//     clear         - clear flags and restart the window (count kept)
//     window_end    - last cycle of the current window (from the top level)
//     status        - 16-bit measurement word
module pwm_channel_meter
   import pwm_duty_capture_pkg::*;
#(
   parameter int WINDOW_BITS = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                pwm_n,
   input  logic                enable,
   input  logic                clear,
   input  logic                window_end,
   output logic [STATUS_W-1:0] status
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [WINDOW_BITS:0]   acc_q;
   logic                   eflag_q;
   logic [WINDOW_BITS:0]   count_q;
   logic                   edge_q;
   logic                   valid_q;

   logic                   sample;
   logic                   active;
   logic                   fall;
   logic [WINDOW_BITS:0]   acc_next;

   // Synchroniser resets to 1 so the line reads inactive until real data arrives.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_n};
      end
   end

   assign sample = sync_q[SYNC_STAGES-1];
   assign active = ~sample;
   assign fall   = prev_q & ~sample;

   // The accumulator holds at most 2^WINDOW_BITS - 1 before the final cycle,
   // so adding the last contribution still fits in WINDOW_BITS+1 bits.
   assign acc_next = acc_q + {{WINDOW_BITS{1'b0}}, active};

   // Edge history keeps tracking while disabled so the first enabled cycle
   // compares against the real previous sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= sample;
      end
   end

   // Precedence: disable > clear > window-end capture > accumulate.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         eflag_q <= 1'b0;
         count_q <= '0;
         edge_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (!enable) begin
         acc_q   <= '0;
         eflag_q <= 1'b0;
         count_q <= '0;
         edge_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (clear) begin
         acc_q   <= '0;
         eflag_q <= 1'b0;
         edge_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (window_end) begin
         count_q <= acc_next;
         edge_q  <= eflag_q | fall;
         valid_q <= 1'b1;
         acc_q   <= '0;
         eflag_q <= 1'b0;
      end else begin
         acc_q   <= acc_next;
         eflag_q <= eflag_q | fall;
      end
   end

   always_comb begin
      status                             = '0;
      status[COUNT_LSB +: WINDOW_BITS+1] = count_q;
      status[EDGE_BIT]                   = edge_q;
      status[VALID_BIT]                  = valid_q;
   end

endmodule

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture
//   Three-channel PWM duty-cycle meter (read side of the RGB LED driver).
//   Counts active-low cycles of each pin over a 2^WINDOW_BITS-cycle window
//   and publishes one 16-bit status word per channel.
//   Ports:
//     clock  - system clock
//     reset  - asynchronous, active-high reset
//     bus    - slave side of pwm_duty_capture_if (pins, control, status words)
module pwm_duty_capture
   import pwm_duty_capture_pkg::*;
#(
   parameter int WINDOW_BITS = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clock,
   input  logic               reset,
   pwm_duty_capture_if.slave  bus
);

   ctrl_t                  ctrl;
   logic [WINDOW_BITS-1:0] win_q;
   logic                   window_end;

   assign ctrl = decode_control(bus.control);

   // Window counter: held at zero while disabled or clearing, otherwise
   // free-runs and wraps, so the first capture lands 2^WINDOW_BITS enabled
   // cycles after enable (or clear) is released.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         win_q <= '0;
      end else if (!ctrl.enable || ctrl.clear) begin
         win_q <= '0;
      end else begin
         win_q <= win_q + 1'b1;
      end
   end

   assign window_end = ctrl.enable & ~ctrl.clear & (&win_q);

   pwm_channel_meter #(
      .WINDOW_BITS (WINDOW_BITS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_red (
      .clock      (clock),
      .reset      (reset),
      .pwm_n      (bus.pwm_red),
      .enable     (ctrl.enable),
      .clear      (ctrl.clear),
      .window_end (window_end),
      .status     (bus.status_red)
   );

   pwm_channel_meter #(
      .WINDOW_BITS (WINDOW_BITS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_grn (
      .clock      (clock),
      .reset      (reset),
      .pwm_n      (bus.pwm_grn),
      .enable     (ctrl.enable),
      .clear      (ctrl.clear),
      .window_end (window_end),
      .status     (bus.status_grn)
   );

   pwm_channel_meter #(
      .WINDOW_BITS (WINDOW_BITS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_blu (
      .clock      (clock),
      .reset      (reset),
      .pwm_n      (bus.pwm_blu),
      .enable     (ctrl.enable),
      .clear      (ctrl.clear),
      .window_end (window_end),
      .status     (bus.status_blu)
   );

endmodule

// File: tb/tb_pwm_duty_capture.sv
// tb_pwm_duty_capture
//   Directed bench for pwm_duty_capture. Pins are driven either manually or
//   by a small LED-driver style generator (8-bit counter, pin low while the
//   counter is below the brightness value).
module tb_pwm_duty_capture;

   logic clock = 1'b0;
   logic reset;

   int tests = 0;
   int fails = 0;

   logic       led_mode = 1'b0;
   logic [7:0] led_cnt  = 8'd0;
   logic [7:0] br_r     = 8'd0;
   logic [7:0] br_g     = 8'd0;
   logic [7:0] br_b     = 8'd0;

   pwm_duty_capture_if bus ();

   pwm_duty_capture dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // One clock: wait for the edge, step 1 time unit off it, advance the
   // generator if it is in charge of the pins.
   task automatic tick();
      @(posedge clock);
      #1;
      if (led_mode) begin
         led_cnt     = led_cnt + 8'd1;
         bus.pwm_red = (led_cnt < br_r) ? 1'b0 : 1'b1;
         bus.pwm_grn = (led_cnt < br_g) ? 1'b0 : 1'b1;
         bus.pwm_blu = (led_cnt < br_b) ? 1'b0 : 1'b1;
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      reset       = 1'b1;
      bus.control = 16'h0000;
      bus.pwm_red = 1'b1;
      bus.pwm_grn = 1'b1;
      bus.pwm_blu = 1'b1;
      tick_n(3);
      check("reset_red", bus.status_red, 16'h0000);
      check("reset_grn", bus.status_grn, 16'h0000);
      check("reset_blu", bus.status_blu, 16'h0000);
      reset = 1'b0;
      tick_n(2);

      // LED driver loopback: red 0x40, green 0xFF, blue 0x00
      br_r        = 8'h40;
      br_g        = 8'hFF;
      br_b        = 8'h00;
      led_mode    = 1'b1;
      bus.control = 16'h0001;
      tick_n(255);
      check("led_before_first_red", bus.status_red, 16'h0000);
      tick_n(257);
      check("led_red", bus.status_red, 16'hC040);
      check("led_grn", bus.status_grn, 16'hC0FF);
      check("led_blu", bus.status_blu, 16'h8000);

      // Async reset mid-window while enabled and toggling
      tick_n(37);
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_red", bus.status_red, 16'h0000);
      check("async_rst_grn", bus.status_grn, 16'h0000);
      check("async_rst_blu", bus.status_blu, 16'h0000);
      tick();
      reset = 1'b0;
      tick_n(255);
      check("post_rst_255_red", bus.status_red, 16'h0000);
      check("post_rst_255_blu", bus.status_blu, 16'h0000);
      tick();
      check("post_rst_256_blu", bus.status_blu, 16'h8000);
      check("post_rst_256_red_valid", {15'd0, bus.status_red[15]}, 16'h0001);

      // Disable forces status to zero on the next edge
      bus.control = 16'h0000;
      tick();
      check("disable_red", bus.status_red, 16'h0000);
      check("disable_grn", bus.status_grn, 16'h0000);

      // Constant low on red, settled before enable
      led_mode    = 1'b0;
      bus.pwm_red = 1'b0;
      bus.pwm_grn = 1'b1;
      bus.pwm_blu = 1'b1;
      tick_n(4);
      bus.control = 16'h0001;
      tick_n(255);
      check("stuck_low_255", bus.status_red, 16'h0000);
      tick();
      check("stuck_low_256", bus.status_red, 16'h8100);
      check("stuck_high_256", bus.status_grn, 16'h8000);
      tick_n(256);
      check("stuck_low_512", bus.status_red, 16'h8100);
      tick_n(88);
      check("stuck_low_600", bus.status_red, 16'h8100);

      // Square wave: 100 low / 156 high, random phase
      bus.control = 16'h0000;
      tick();
      led_cnt     = 8'($urandom_range(0, 255));
      br_r        = 8'd100;
      br_g        = 8'd0;
      br_b        = 8'd0;
      led_mode    = 1'b1;
      bus.control = 16'h0001;
      tick_n(512);
      check("square_red", bus.status_red, 16'hC064);
      check("square_grn", bus.status_grn, 16'h8000);

      // One-cycle clear_flags pulse
      bus.control = 16'h0003;
      tick();
      bus.control = 16'h0001;
      check("clear_red", bus.status_red, 16'h0064);
      tick_n(255);
      check("clear_hold_255", bus.status_red, 16'h0064);
      tick();
      check("clear_recapture_256", bus.status_red, 16'hC064);

      // Drop enable exactly on the window-end cycle
      tick_n(255);
      check("pre_window_end_red", bus.status_red, 16'hC064);
      bus.control = 16'h0000;
      tick();
      check("drop_at_end_red", bus.status_red, 16'h0000);
      check("drop_at_end_grn", bus.status_grn, 16'h0000);
      check("drop_at_end_blu", bus.status_blu, 16'h0000);

      // Re-enable: first result exactly 256 cycles later
      bus.control = 16'h0001;
      tick_n(255);
      check("reenable_255_red", bus.status_red, 16'h0000);
      tick();
      check("reenable_256_red", bus.status_red, 16'hC064);
      check("reenable_256_blu", bus.status_blu, 16'h8000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pwm_duty_capture.md
Name: pwm_duty_capture

Overview:
Three-channel PWM duty-cycle meter. It is the read side of the RGB LED PWM driver. It samples three active-low PWM lines, counts active cycles over a fixed window, and presents the results as 16-bit memory-mapped status words that the CPU reads. Typical uses are LED-driver loopback self-test and reading external PWM sources.

Parameters:
WINDOW_BITS, 8, window length is 2^WINDOW_BITS clock cycles (default 256, matching the LED driver's 8-bit brightness counter).
SYNC_STAGES, 2, depth of the input synchroniser flop chain per channel (minimum 2).

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
pwm_red  input  1  red PWM line, active low, asynchronous to clock.
pwm_grn  input  1  green PWM line, active low, asynchronous.
pwm_blu  input  1  blue PWM line, active low, asynchronous.
control  input  16  bit0 = enable, bit1 = clear_flags (level), bits 15:2 ignored.
status_red  output  16  red measurement word.
status_grn  output  16  green measurement word.
status_blu  output  16  blue measurement word.

Behaviour:
- Status word layout, identical for all channels:
  - [8:0] active_count, range 0..2^WINDOW_BITS.
  - [13:9] zero.
  - [14] edge_seen: at least one inactive-to-active (1 to 0) transition occurred in the last window.
  - [15] valid: at least one window has completed since enable or clear.
- Reset (async, any time): all status words 16'h0; window counter 0; accumulators 0; synchroniser flops 1 (inactive); edge-history flops 1.
- Synchroniser: each input passes through SYNC_STAGES flops. Latency from pin to sampled value is SYNC_STAGES cycles. All counting uses only the synchronised value.
- enable = 0:
  - window counter and accumulators held at 0.
  - status words forced to 0 on the next edge.
  - no capture occurs.
- enable = 1, every cycle:
  - window counter increments, wrapping modulo 2^WINDOW_BITS.
  - each channel accumulator increments when its synchronised sample is 0.
  - the edge flag sets when the previous sample was 1 and the current sample is 0.
- Window end (window counter = 2^WINDOW_BITS - 1 and enable = 1), on the same edge:
  - active_count is loaded with accumulator plus the current cycle's contribution. Width is WINDOW_BITS+1, so no overflow.
  - edge_seen is loaded with the edge flag, including the current cycle.
  - valid is set.
  - accumulator and edge flag restart at 0 for the next window.
- Status fields hold between window ends. The first capture occurs exactly 2^WINDOW_BITS enabled cycles after enable rises.
- A steady-state PWM with period 2^WINDOW_BITS measures exactly its active-cycle count, independent of phase alignment.
- clear_flags = 1 (with enable = 1):
  - valid and edge_seen cleared.
  - window counter and accumulators restart at 0.
  - active_count retains its last value.
  - while clear_flags is held, no capture occurs.
- Precedence on any edge: reset > enable = 0 > clear_flags > window-end capture.
- Constant-low input gives active_count = 256 with edge_seen = 0. Constant-high input gives 0 with edge_seen = 0. Software reads these cases as stuck lines.
- Reset or disable mid-window: the partial window is discarded and no partial result is ever published.

Decomposition:
- Shared package holds:
  - status bit-position constants: COUNT_LSB = 0, COUNT_MSB = 8, EDGE_BIT = 14, VALID_BIT = 15.
  - control bit constants: ENABLE_BIT = 0, CLEAR_BIT = 1.
- One sub-module, pwm_channel_meter, instantiated three times. It contains the synchroniser, edge detect, accumulator and status register, and takes the shared window_end / clear / enable strobes.
- The top level owns the window counter and decodes the control word.

Test Plan:
- Reset asserted mid-run with enable = 1 and inputs toggling → all status words 16'h0000 immediately (async), and they remain 0 until 256 enabled cycles after reset release.
- enable = 1; drive the pins from an rgb_led instance with brightnesses red = 0x40, green = 0xFF, blue = 0x00 → after two windows, status_red = 16'hC040, status_grn = 16'hC0FF, status_blu = 16'h8000.
- Constant low on pwm_red for 600 cycles after enable → status_red = 16'h8100 (count 256, edge_seen 0, valid 1), updated at cycles 256 and 512.
- Square wave 100 cycles low / 156 cycles high, random phase → active_count = 100, edge_seen = 1.
  - Then pulse clear_flags for 1 cycle → valid = 0 and edge_seen = 0, count still 100.
  - The next capture arrives 256 cycles after the clear is released.
- Drop enable at the exact window-end cycle → no capture, all status words 0 on the next edge.
  - Re-enable → first valid result exactly 256 cycles later.
